// File: rtl/servo_cap_pkg.sv
// servo_cap_pkg
//   Shared definitions for the servo pulse capture block:
//     - FSM state encoding (idle / measuring high time / measuring low time)
//     - default values for the top-level parameters
//     - saturating increment used by the microsecond counters
//   The saturating increment works on 32-bit values, so the counter width
//   used with it must not exceed 32 bits.

package servo_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned CLK_DIV_DEF    = 80;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned MIN_US_DEF     = 500;
  localparam int unsigned MAX_US_DEF     = 2500;
  localparam int unsigned TIMEOUT_US_DEF = 25000;
  localparam int unsigned FILT_LEN_DEF   = 4;

  // Increment v by one, but never past max_v (the counter's all-ones value).
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    if (v >= max_v) begin
      return max_v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/servo_cap_sync_filter.sv
// servo_cap_sync_filter
//   Brings the asynchronous servo pin into the clock domain and produces
//   single-cycle rise/fall pulses.
//     pin -> 2-flop synchronizer -> [optional glitch filter] -> edge register
//   Optional feature macro: SERVO_CAP_FILTER_EN
//     defined   : a FILT_LEN-clock glitch filter sits after the synchronizer;
//                 pin-to-edge latency is 3 + FILT_LEN clocks.
//     undefined : no filter; pin-to-edge latency is 3 clocks and single-clock
//                 pulses are passed through.
//   Rising and falling edges see the same latency, so measured widths are exact.
//
// Ports
//   i_clk   in   sole clock
//   i_rst   in   synchronous active-high reset
//   i_pin   in   asynchronous servo pulse input
//   o_rise  out  1-cycle pulse on a rising edge of the cleaned input
//   o_fall  out  1-cycle pulse on a falling edge of the cleaned input

module servo_cap_sync_filter
  import servo_cap_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;
  logic r_fall;
  logic w_clean;

  // The chain resets to 1 so that a line already high when reset releases
  // never produces a rise; a line that is low produces a fall, which the FSM
  // ignores while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SERVO_CAP_FILTER_EN
  localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FC_W-1:0] r_fcnt;
  logic            r_filt;

  // r_fcnt counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILT_LEN-th disagreeing sample in a row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FC_W'(FILT_LEN - 1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_clean = r_filt;
`else
  // The filter length has no role when the filter is not built.
  logic [31:0] w_filt_len_unused;
  assign w_filt_len_unused = 32'(FILT_LEN);

  assign w_clean = r_sync2;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_clean;
      r_rise <= w_clean & ~r_prev;
      r_fall <= ~w_clean & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/servo_pulse_capture.sv
// servo_pulse_capture
//   Servo-style PWM receiver. Measures the high time and the rising-to-rising
//   period of a pulse train in microseconds, range-checks the high time and
//   publishes results with single-cycle strobes. Detects signal loss when the
//   line stays in one level for TIMEOUT_US.
//   Optional feature macro: SERVO_CAP_FILTER_EN (glitch filter in the input
//   path, see servo_cap_sync_filter).
//
// Ports
//   inCLK           in   sole clock
//   reset           in   synchronous active-high reset
//   enable          in   0 forces the FSM idle, discards any measurement,
//                        holds the result registers and clears signal_present
//   pwm_in          in   asynchronous servo pulse from the pin
//   pulse_us        out  last accepted high time (us)
//   pulse_valid     out  1-cycle strobe when pulse_us updates
//   period_us       out  last rising-to-rising period (us)
//   period_valid    out  1-cycle strobe when period_us updates
//   range_err       out  1-cycle strobe when a high time is outside [MIN_US, MAX_US]
//   timeout         out  1-cycle strobe on signal loss
//   signal_present  out  level, set by an accepted pulse, cleared by timeout,
//                        reset or enable=0
//
// FSM states
//   state   | meaning
//   ST_IDLE | no measurement running; waiting for a rising edge
//   ST_HIGH | line high; counting the high time
//   ST_LOW  | line low after a pulse; waiting for the next rise to close the period

module servo_pulse_capture
  import servo_cap_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MIN_US     = MIN_US_DEF,
  parameter int unsigned MAX_US     = MAX_US_DEF,
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int unsigned FILT_LEN   = FILT_LEN_DEF
) (
  input  logic             inCLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_us,
  output logic             pulse_valid,
  output logic [CNT_W-1:0] period_us,
  output logic             period_valid,
  output logic             range_err,
  output logic             timeout,
  output logic             signal_present
);

  localparam int unsigned      DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_US);

  logic             w_rise;
  logic             w_fall;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] w_hi_inc;
  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_hi_now;
  logic [CNT_W-1:0] w_per_now;
  logic             w_clr_cnt;
  logic             w_in_range;
  logic             w_to_hit;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ld_pulse;
  logic             w_ld_period;
  logic             w_rng_err;
  logic             w_to;

  servo_cap_sync_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_filter (
    .i_clk  (inCLK),
    .i_rst  (reset),
    .i_pin  (pwm_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // 1 us tick divider, phase-aligned to every rising edge so that both the
  // high time and the period start on a fresh microsecond.
  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge inCLK) begin
    if (reset || w_rise || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // The *_now values include this cycle's tick, so a value sampled on an
  // edge cycle equals floor(elapsed clocks / CLK_DIV) since the last rise.
  assign w_hi_inc  = CNT_W'(sat_inc(32'(r_hi_cnt),  32'(CNT_MAX)));
  assign w_per_inc = CNT_W'(sat_inc(32'(r_per_cnt), 32'(CNT_MAX)));
  assign w_hi_now  = w_tick ? w_hi_inc  : r_hi_cnt;
  assign w_per_now = w_tick ? w_per_inc : r_per_cnt;

  assign w_in_range = (w_hi_now >= MIN_C) && (w_hi_now <= MAX_C);
  assign w_to_hit   = (r_per_cnt == TO_C);

  // Every rise starts a new high time and a new period; enable=0 throws the
  // running measurement away.
  assign w_clr_cnt = w_rise || !enable;

  always_ff @(posedge inCLK) begin
    if (reset || w_clr_cnt) begin
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else begin
      r_hi_cnt  <= w_hi_now;
      r_per_cnt <= w_per_now;
    end
  end

  always_ff @(posedge inCLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout is tested before edges so that an edge landing on the timeout
  // cycle is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_pulse  = 1'b0;
    w_ld_period = 1'b0;
    w_rng_err   = 1'b0;
    w_to        = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_to_hit || (r_hi_cnt == TO_C)) begin
            w_to        = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_fall) begin
            if (w_in_range) begin
              w_ld_pulse = 1'b1;
            end else begin
              w_rng_err = 1'b1;
            end
            w_state_nxt = ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_to_hit) begin
            w_to        = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_rise) begin
            w_ld_period = 1'b1;
            w_state_nxt = ST_HIGH;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge inCLK) begin
    if (reset) begin
      pulse_us       <= '0;
      pulse_valid    <= 1'b0;
      period_us      <= '0;
      period_valid   <= 1'b0;
      range_err      <= 1'b0;
      timeout        <= 1'b0;
      signal_present <= 1'b0;
    end else begin
      pulse_valid  <= w_ld_pulse;
      period_valid <= w_ld_period;
      range_err    <= w_rng_err;
      timeout      <= w_to;
      if (w_ld_pulse) begin
        pulse_us <= w_hi_now;
      end
      if (w_ld_period) begin
        period_us <= w_per_now;
      end
      if (!enable || w_to) begin
        signal_present <= 1'b0;
      end else if (w_ld_pulse) begin
        signal_present <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_capture.sv
// Bench for servo_pulse_capture. Time constants are scaled down by 100
// (MIN 5, MAX 25, TIMEOUT 250 us) with CLK_DIV=4 so the run stays short;
// a 1500 us / 20000 us servo frame becomes 15 us / 200 us.
module tb_servo_pulse_capture;

  localparam int D = 4;

  localparam int EV_PULSE  = 0;
  localparam int EV_PERIOD = 1;
  localparam int EV_RANGE  = 2;
  localparam int EV_TO     = 3;

  typedef struct {
    int          kind;
    logic [31:0] value;
  } evt_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pwm_in;
  logic [15:0] pulse_us;
  logic        pulse_valid;
  logic [15:0] period_us;
  logic        period_valid;
  logic        range_err;
  logic        timeout;
  logic        signal_present;

  evt_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  servo_pulse_capture #(
    .CLK_DIV    (D),
    .CNT_W      (16),
    .MIN_US     (5),
    .MAX_US     (25),
    .TIMEOUT_US (250),
    .FILT_LEN   (4)
  ) dut (
    .inCLK          (clk),
    .reset          (reset),
    .enable         (enable),
    .pwm_in         (pwm_in),
    .pulse_us       (pulse_us),
    .pulse_valid    (pulse_valid),
    .period_us      (period_us),
    .period_valid   (period_valid),
    .range_err      (range_err),
    .timeout        (timeout),
    .signal_present (signal_present)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(int k);
    case (k)
      EV_PULSE:  return "pulse_valid";
      EV_PERIOD: return "period_valid";
      EV_RANGE:  return "range_err";
      default:   return "timeout";
    endcase
  endfunction

  task automatic push(int kind, int value);
    evt_t e;
    e.kind  = kind;
    e.value = 32'(value);
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // range_err carries the retained pulse_us; timeout carries signal_present.
  task automatic sb_check(int kind, logic [31:0] act);
    evt_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: %s strobe with value %0d, nothing expected at %0t",
               kname(kind), act, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.value !== act) begin
        n_errors++;
        $display("FAIL sb_%s: got %s value %0d, expected %s value %0d at %0t",
                 kname(e.kind), kname(kind), act, kname(e.kind), e.value, $time);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (period_valid) sb_check(EV_PERIOD, 32'(period_us));
      if (pulse_valid)  sb_check(EV_PULSE,  32'(pulse_us));
      if (range_err)    sb_check(EV_RANGE,  32'(pulse_us));
      if (timeout)      sb_check(EV_TO,     32'(signal_present));
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int hi_us, int lo_us);
    pwm_in = 1'b1;
    wait_clk(hi_us * D);
    pwm_in = 1'b0;
    wait_clk(lo_us * D);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    wait_clk(3);
    chk("rst_pulse_us",       32'(pulse_us),       0);
    chk("rst_pulse_valid",    32'(pulse_valid),    0);
    chk("rst_period_us",      32'(period_us),      0);
    chk("rst_period_valid",   32'(period_valid),   0);
    chk("rst_range_err",      32'(range_err),      0);
    chk("rst_timeout",        32'(timeout),        0);
    chk("rst_signal_present", 32'(signal_present), 0);
    wait_clk(10);

    // Three 15 us / 200 us frames, then the line stays low into a timeout.
    push(EV_PULSE, 15);
    pulse(15, 185);
    chk("t1_present_after_first", 32'(signal_present), 1);
    chk("t1_pulse_us",            32'(pulse_us),       15);
    push(EV_PERIOD, 200);
    push(EV_PULSE, 15);
    pulse(15, 185);
    push(EV_PERIOD, 200);
    push(EV_PULSE, 15);
    push(EV_TO, 0);
    pulse(15, 225);
    chk("t1_present_before_to", 32'(signal_present), 1);
    wait_clk(75 * D);
    chk("t1_present_after_to", 32'(signal_present), 0);
    chk("t1_period_us",        32'(period_us),      200);

    // Reset for one cycle in the middle of a high time: nothing reported.
    pwm_in = 1'b1;
    wait_clk(10 * D);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(5 * D);
    pwm_in = 1'b0;
    wait_clk(20 * D);
    chk("rst_mid_pulse_us",  32'(pulse_us),       0);
    chk("rst_mid_period_us", 32'(period_us),      0);
    chk("rst_mid_present",   32'(signal_present), 0);

    // Too short, too long, then both inclusive boundaries.
    push(EV_RANGE, 0);
    pulse(4, 20);
    chk("short_keeps_pulse_us", 32'(pulse_us), 0);
    push(EV_PERIOD, 24);
    push(EV_RANGE, 0);
    pulse(26, 20);
    chk("long_present", 32'(signal_present), 0);
    push(EV_PERIOD, 46);
    push(EV_PULSE, 25);
    pulse(25, 20);
    chk("max_pulse_us", 32'(pulse_us), 25);
    push(EV_PERIOD, 45);
    push(EV_PULSE, 5);
    push(EV_TO, 0);
    pulse(5, 300);
    chk("min_pulse_us",      32'(pulse_us),       5);
    chk("min_period_us",     32'(period_us),      45);
    chk("min_to_present",    32'(signal_present), 0);

    // Clean restart from idle, then enable dropped mid-pulse.
    push(EV_PULSE, 10);
    pulse(10, 20);
    chk("restart_present", 32'(signal_present), 1);
    push(EV_PERIOD, 30);
    pwm_in = 1'b1;
    wait_clk(5 * D);
    enable = 1'b0;
    wait_clk(3);
    enable = 1'b1;
    wait_clk(7 * D - 3);
    pwm_in = 1'b0;
    wait_clk(300 * D);
    chk("en_present",  32'(signal_present), 0);
    chk("en_pulse_us", 32'(pulse_us),       10);

    // 10 us pulse broken by two 2-clock low glitches.
`ifdef SERVO_CAP_FILTER_EN
    push(EV_PULSE, 10);
`else
    push(EV_RANGE, 10);
    push(EV_PERIOD, 3);
    push(EV_RANGE, 10);
    push(EV_PERIOD, 3);
    push(EV_RANGE, 10);
`endif
    push(EV_TO, 0);
    pwm_in = 1'b1;
    wait_clk(12);
    pwm_in = 1'b0;
    wait_clk(2);
    pwm_in = 1'b1;
    wait_clk(12);
    pwm_in = 1'b0;
    wait_clk(2);
    pwm_in = 1'b1;
    wait_clk(12);
    pwm_in = 1'b0;
    wait_clk(300 * D);
    chk("glitch_present",  32'(signal_present), 0);
    chk("glitch_pulse_us", 32'(pulse_us),       10);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d expected strobes never seen, first is %s value %0d",
               q.size(), kname(q[0].kind), q[0].value);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
